// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: step, stall, relative branch, absolute jump, halt/resume.
// Define PC_RAS_EN to build the return-address stack for call/ret (otherwise call == jump, ret ignored).
module pc_sequencer #(
    parameter int         WIDTH      = 7,
    parameter int         STEP       = 4,
    parameter int         RESET_ADDR = 0,
    parameter logic [6:0] HALT_OP    = 7'b0000001,
    parameter int         RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode_in,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic             resume,
    output logic [WIDTH-1:0] pointer,
    output logic             halted,
    output logic             ras_err
);

    localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_ADDR);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pointer_q, pointer_d;
    logic [WIDTH-1:0] seq_next;

    assign seq_next = pointer_q + STEP_V;

`ifdef PC_RAS_EN
    localparam int SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = SP_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    // sp_q addresses the next free slot; when full it also addresses the oldest entry.
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ras_err_q, ras_err_d;
    logic             push_en, pop_en;
    logic [SP_W-1:0]  top_idx;

    assign top_idx = sp_q - SP_W'(1);
`else
    logic unused_ret;
    assign unused_ret = ret_en;
`endif

    always_comb begin
        state_d   = state_q;
        pointer_d = pointer_q;
`ifdef PC_RAS_EN
        ras_err_d = ras_err_q;
        push_en   = 1'b0;
        pop_en    = 1'b0;
`endif
        case (state_q)
            RUN: begin
                if (stall) begin
                    pointer_d = pointer_q;
                end else if (opcode_in == HALT_OP) begin
                    state_d = HALTED;
`ifdef PC_RAS_EN
                end else if (ret_en) begin
                    if (cnt_q == '0) begin
                        pointer_d = seq_next;
                        ras_err_d = 1'b1;
                    end else begin
                        pointer_d = stack_q[top_idx];
                        pop_en    = 1'b1;
                    end
                end else if (call_en) begin
                    push_en   = 1'b1;
                    pointer_d = jump_target;
                    if (cnt_q == FULL_CNT) begin
                        ras_err_d = 1'b1;
                    end
`else
                end else if (call_en) begin
                    pointer_d = jump_target;
`endif
                end else if (jump_en) begin
                    pointer_d = jump_target;
                end else if (branch_taken) begin
                    pointer_d = pointer_q + branch_offset;
                end else begin
                    pointer_d = seq_next;
                end
            end
            HALTED: begin
                // Resume skips past the HALT instruction itself.
                if (!stall && resume) begin
                    state_d   = RUN;
                    pointer_d = seq_next;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pointer_q <= RESET_V;
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
        end
    end

`ifdef PC_RAS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q      <= '0;
            cnt_q     <= '0;
            ras_err_q <= 1'b0;
        end else begin
            ras_err_q <= ras_err_d;
            if (push_en) begin
                sp_q <= sp_q + SP_W'(1);
                if (cnt_q != FULL_CNT) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (pop_en) begin
                sp_q  <= top_idx;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Stack contents need no reset: the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            stack_q[sp_q] <= seq_next;
        end
    end

    assign ras_err = ras_err_q;
`else
    assign ras_err = 1'b0;
`endif

    assign pointer = pointer_q;
    assign halted  = (state_q == HALTED);

endmodule
